// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU bus responder: RAM, output port, reset/IRQ vectors, optional countdown timer
//
// Purpose:
//   Answers a simple 8-bit CPU bus with a 1-cycle registered read path.
//   RAM occupies 0x0000..(2^RAM_ADDR_BITS - 1).
//   The output port is at 0xD004.
//   The reset and IRQ vectors are at 0xFFFC..0xFFFF.
//   A 16-bit countdown timer is at 0xD000..0xD003 and 0xD005..0xD006.
//   The timer is only built when the macro BUS_RESPONDER_TIMER_EN is defined.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   address     16-bit bus address
//   read_write  1 = read, 0 = write
//   data_write  write data, used when read_write = 0
//   data_read   registered read data
//   port_out    general-purpose output port register
//   timer_irq   timer interrupt request (active-high level)

module bus_responder #(
    parameter int          RAM_ADDR_BITS = 11,
    parameter logic [15:0] RESET_VECTOR  = 16'h0200,
    parameter logic [15:0] IRQ_VECTOR    = 16'h0300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    output logic [7:0]  port_out,
    output logic        timer_irq
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_BITS;

    localparam logic [15:0] ADDR_RELOAD_LO = 16'hD000;
    localparam logic [15:0] ADDR_RELOAD_HI = 16'hD001;
    localparam logic [15:0] ADDR_CTRL      = 16'hD002;
    localparam logic [15:0] ADDR_STATUS    = 16'hD003;
    localparam logic [15:0] ADDR_PORT      = 16'hD004;
    localparam logic [15:0] ADDR_COUNT_LO  = 16'hD005;
    localparam logic [15:0] ADDR_COUNT_HI  = 16'hD006;

    logic [7:0] ram [RAM_DEPTH];
    logic [7:0] port_reg;
    logic [7:0] read_value;
    logic       ram_hit;
    logic       rd;
    logic       wr_io;

    // RAM decode wins over the register page if RAM is ever sized to cover it.
    assign ram_hit = ((32'(address) >> RAM_ADDR_BITS) == 32'd0);
    assign rd      = read_write;
    assign wr_io   = !read_write && !ram_hit;

    // RAM has no reset, so its contents survive rst.
    always_ff @(posedge clk) begin
        if (!read_write && ram_hit) begin
            ram[address[RAM_ADDR_BITS-1:0]] <= data_write;
        end
    end

`ifdef BUS_RESPONDER_TIMER_EN
    typedef enum logic {
        TIMER_IDLE,
        TIMER_RUN
    } timer_state_t;

    timer_state_t timer_state;
    logic [7:0]   reload_lo;
    logic [7:0]   reload_hi;
    logic [2:0]   ctrl;
    logic         status;
    logic [15:0]  counter;
    logic [7:0]   snapshot;
    logic         expire;
    logic         status_clear;

    assign expire       = (timer_state == TIMER_RUN) && (counter == 16'h0000);
    assign status_clear = wr_io && (address == ADDR_STATUS) && data_write[0];
    assign timer_irq    = status && ctrl[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_state <= TIMER_IDLE;
            reload_lo   <= 8'h00;
            reload_hi   <= 8'h00;
            ctrl        <= 3'b000;
            status      <= 1'b0;
            counter     <= 16'h0000;
            snapshot    <= 8'h00;
        end else begin
            // A read of the low byte freezes the high byte so software
            // gets a coherent 16-bit value across two reads.
            if (rd && !ram_hit && (address == ADDR_COUNT_LO)) begin
                snapshot <= counter[15:8];
            end
            // Reload writes only land in the holding registers; the
            // running count picks them up at the next reload or enable.
            if (wr_io && (address == ADDR_RELOAD_LO)) begin
                reload_lo <= data_write;
            end
            if (wr_io && (address == ADDR_RELOAD_HI)) begin
                reload_hi <= data_write;
            end

            // Expiry set takes priority over a same-cycle write-1-to-clear.
            status <= expire | (status & ~status_clear);

            if (wr_io && (address == ADDR_CTRL)) begin
                ctrl <= data_write[2:0];
                if (data_write[0]) begin
                    counter     <= {reload_hi, reload_lo};
                    timer_state <= TIMER_RUN;
                end else begin
                    timer_state <= TIMER_IDLE;
                end
            end else if (timer_state == TIMER_RUN) begin
                if (counter == 16'h0000) begin
                    if (ctrl[1]) begin
                        counter <= {reload_hi, reload_lo};
                    end else begin
                        ctrl[0]     <= 1'b0;
                        timer_state <= TIMER_IDLE;
                    end
                end else begin
                    counter <= counter - 16'd1;
                end
            end
        end
    end
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        read_value = 8'h00;
        if (ram_hit) begin
            read_value = ram[address[RAM_ADDR_BITS-1:0]];
        end else begin
            case (address)
                ADDR_PORT:      read_value = port_reg;
                16'hFFFC:       read_value = RESET_VECTOR[7:0];
                16'hFFFD:       read_value = RESET_VECTOR[15:8];
                16'hFFFE:       read_value = IRQ_VECTOR[7:0];
                16'hFFFF:       read_value = IRQ_VECTOR[15:8];
`ifdef BUS_RESPONDER_TIMER_EN
                ADDR_RELOAD_LO: read_value = reload_lo;
                ADDR_RELOAD_HI: read_value = reload_hi;
                ADDR_CTRL:      read_value = {5'b00000, ctrl};
                ADDR_STATUS:    read_value = {7'b0000000, status};
                ADDR_COUNT_LO:  read_value = counter[7:0];
                ADDR_COUNT_HI:  read_value = snapshot;
`endif
                default:        read_value = 8'h00;
            endcase
        end
    end

    // data_read only changes on read cycles, so it holds through writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_read <= 8'h00;
            port_reg  <= 8'h00;
        end else begin
            if (rd) begin
                data_read <= read_value;
            end
            if (wr_io && (address == ADDR_PORT)) begin
                port_reg <= data_write;
            end
        end
    end

    assign port_out = port_reg;

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - self-checking bench for bus_responder
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = 16'hE000;
    logic        read_write = 1'b1;
    logic [7:0]  data_write = 8'h00;
    logic [7:0]  data_read;
    logic [7:0]  port_out;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_model [2048];

    bus_responder dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .read_write (read_write),
        .data_write (data_write),
        .data_read  (data_read),
        .port_out   (port_out),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    // One bus cycle: drive, wait for the edge, settle 1 ns past it.
    task automatic bus(input logic [15:0] a, input logic rw, input logic [7:0] d);
        address    = a;
        read_write = rw;
        data_write = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus(16'hE000, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (data_read !== 8'h00) begin errors++; $display("FAIL reset_data_read got %h want 00", data_read); end
        checks++;
        if (port_out !== 8'h00) begin errors++; $display("FAIL reset_port_out got %h want 00", port_out); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_timer_irq got %b want 0", timer_irq); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus(16'hD004, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'h00) begin errors++; $display("FAIL reset_port_read got %h want 00", data_read); end
    endtask

    task automatic test_ram();
        logic [10:0] addrs [16];
        logic [7:0]  v;
        logic [7:0]  held;
        // Write-then-read-next-cycle
        bus(16'h0123, 1'b0, 8'hA5);
        ram_model[11'h123] = 8'hA5;
        bus(16'h0123, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'hA5) begin errors++; $display("FAIL ram_rdaw got %h want a5", data_read); end
        for (int i = 0; i < 16; i++) begin
            addrs[i] = 11'($urandom_range(0, 2047));
            if (addrs[i] == 11'h123) addrs[i] = 11'h124;
            v = 8'($urandom);
            bus({5'b0, addrs[i]}, 1'b0, v);
            ram_model[addrs[i]] = v;
        end
        for (int i = 15; i >= 0; i--) begin
            bus({5'b0, addrs[i]}, 1'b1, 8'h00);
            checks++;
            if (data_read !== ram_model[addrs[i]])
                begin errors++; $display("FAIL ram_read addr %h got %h want %h", addrs[i], data_read, ram_model[addrs[i]]); end
        end
        // Random write immediately followed by its read
        for (int i = 0; i < 6; i++) begin
            addrs[0] = 11'($urandom_range(0, 2047));
            if (addrs[0] == 11'h123) addrs[0] = 11'h7FF;
            v = 8'($urandom);
            bus({5'b0, addrs[0]}, 1'b0, v);
            ram_model[addrs[0]] = v;
            bus({5'b0, addrs[0]}, 1'b1, 8'h00);
            checks++;
            if (data_read !== v) begin errors++; $display("FAIL ram_b2b addr %h got %h want %h", addrs[0], data_read, v); end
        end
        // data_read holds through a write cycle
        held = ram_model[addrs[0]];
        bus({5'b0, addrs[0]}, 1'b0, ~held);
        ram_model[addrs[0]] = ~held;
        checks++;
        if (data_read !== held) begin errors++; $display("FAIL read_hold got %h want %h", data_read, held); end
    endtask

    task automatic test_vectors();
        logic [15:0] rv = 16'h0200;
        logic [15:0] iv = 16'h0300;
        logic [7:0]  exp [4];
        exp[0] = rv[7:0]; exp[1] = rv[15:8]; exp[2] = iv[7:0]; exp[3] = iv[15:8];
        for (int i = 0; i < 4; i++) begin
            bus(16'hFFFC + 16'(i), 1'b1, 8'h00);
            checks++;
            if (data_read !== exp[i]) begin errors++; $display("FAIL vector_%0d got %h want %h", i, data_read, exp[i]); end
        end
        bus(16'hFFFC, 1'b0, 8'h55);
        bus(16'hFFFC, 1'b1, 8'h00);
        checks++;
        if (data_read !== exp[0]) begin errors++; $display("FAIL vector_write_ignored got %h want %h", data_read, exp[0]); end
    endtask

    task automatic test_unmapped();
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h0800, 16'hCFFF))
                                             : 16'($urandom_range(16'hD007, 16'hFFFB));
            bus(a, 1'b0, 8'($urandom));
            bus(16'h0123, 1'b1, 8'h00);
            bus(a, 1'b1, 8'h00);
            checks++;
            if (data_read !== 8'h00) begin errors++; $display("FAIL unmapped addr %h got %h want 00", a, data_read); end
        end
        bus(16'h0123, 1'b1, 8'h00);
        checks++;
        if (data_read !== ram_model[11'h123]) begin errors++; $display("FAIL unmapped_no_alias got %h want %h", data_read, ram_model[11'h123]); end
    endtask

    task automatic test_port();
        logic [7:0] v;
        for (int i = 0; i < 5; i++) begin
            v = 8'($urandom);
            bus(16'hD004, 1'b0, v);
            checks++;
            if (port_out !== v) begin errors++; $display("FAIL port_out got %h want %h", port_out, v); end
            bus(16'hD004, 1'b1, 8'h00);
            checks++;
            if (data_read !== v) begin errors++; $display("FAIL port_read got %h want %h", data_read, v); end
        end
    endtask

`ifdef BUS_RESPONDER_TIMER_EN
    // Model: expiries land at edges k*(r+1) after the enabling write; status
    // is sticky until a write-1-to-clear, and a same-edge expiry wins.
    task automatic test_timer_auto(input int r);
        logic st = 1'b0;
        logic clr;
        bus(16'hD000, 1'b0, 8'(r));
        bus(16'hD001, 1'b0, 8'h00);
        bus(16'hD002, 1'b0, 8'h07);
        for (int k = 1; k <= 4 * (r + 1) + 2; k++) begin
            clr = ($urandom_range(0, 2) == 0);
            if (clr) bus(16'hD003, 1'b0, 8'h01); else idle();
            if (clr) st = 1'b0;
            if (k % (r + 1) == 0) st = 1'b1;
            checks++;
            if (timer_irq !== st) begin errors++; $display("FAIL timer_auto r=%0d k=%0d got %b want %b", r, k, timer_irq, st); end
        end
        bus(16'hD002, 1'b0, 8'h00);
        bus(16'hD003, 1'b0, 8'h01);
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_clear got %b want 0", timer_irq); end
    endtask

    task automatic test_timer_oneshot(input int r);
        bus(16'hD000, 1'b0, 8'(r));
        bus(16'hD001, 1'b0, 8'h00);
        bus(16'hD002, 1'b0, 8'h05);
        for (int k = 1; k <= r + 3; k++) begin
            idle();
            checks++;
            if (timer_irq !== (k >= r + 1)) begin errors++; $display("FAIL timer_oneshot r=%0d k=%0d got %b want %b", r, k, timer_irq, (k >= r + 1)); end
        end
        bus(16'hD002, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'h04) begin errors++; $display("FAIL oneshot_ctrl got %h want 04", data_read); end
        bus(16'hD005, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'h00) begin errors++; $display("FAIL oneshot_count got %h want 00", data_read); end
        bus(16'hD003, 1'b0, 8'h01);
        bus(16'hD003, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'h00) begin errors++; $display("FAIL oneshot_status_clear got %h want 00", data_read); end
    endtask

    task automatic test_timer_snapshot();
        logic [15:0] cnt;
        bus(16'hD000, 1'b0, 8'h00);
        bus(16'hD001, 1'b0, 8'h01);
        bus(16'hD002, 1'b0, 8'h01);
        bus(16'hD005, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'h00) begin errors++; $display("FAIL snap_lo got %h want 00", data_read); end
        idle();
        bus(16'hD006, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'h01) begin errors++; $display("FAIL snap_hi got %h want 01", data_read); end
        // Reload writes while running must not disturb the count
        bus(16'hD000, 1'b0, 8'h02);
        bus(16'hD001, 1'b0, 8'h00);
        cnt = 16'h0100 - 16'd5;
        bus(16'hD005, 1'b1, 8'h00);
        checks++;
        if (data_read !== cnt[7:0]) begin errors++; $display("FAIL reload_in_run got %h want %h", data_read, cnt[7:0]); end
        bus(16'hD002, 1'b0, 8'h00);
    endtask
`else
    task automatic test_timer_absent();
        logic [15:0] regs [6];
        regs[0] = 16'hD000; regs[1] = 16'hD001; regs[2] = 16'hD002;
        regs[3] = 16'hD003; regs[4] = 16'hD005; regs[5] = 16'hD006;
        for (int i = 0; i < 6; i++) bus(regs[i], 1'b0, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            bus(16'h0123, 1'b1, 8'h00);
            bus(regs[i], 1'b1, 8'h00);
            checks++;
            if (data_read !== 8'h00) begin errors++; $display("FAIL no_timer_reg %h got %h want 00", regs[i], data_read); end
        end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL no_timer_irq got %b want 0", timer_irq); end
    endtask
`endif

    task automatic test_reset_mid();
        bus(16'h0123, 1'b0, 8'hA5);
        ram_model[11'h123] = 8'hA5;
        bus(16'hD004, 1'b0, 8'h3C);
`ifdef BUS_RESPONDER_TIMER_EN
        bus(16'hD000, 1'b0, 8'h01);
        bus(16'hD001, 1'b0, 8'h00);
        bus(16'hD002, 1'b0, 8'h07);
        for (int k = 0; k < 3; k++) idle();
        checks++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", timer_irq); end
        bus(16'hD000, 1'b0, 8'h40);
        bus(16'hD002, 1'b0, 8'h07);
        idle();
`endif
        bus(16'h0123, 1'b1, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (port_out !== 8'h00) begin errors++; $display("FAIL async_port_out got %h want 00", port_out); end
        checks++;
        if (data_read !== 8'h00) begin errors++; $display("FAIL async_data_read got %h want 00", data_read); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL async_timer_irq got %b want 0", timer_irq); end
        #2;
        rst = 1'b0;
        bus(16'h0123, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'hA5) begin errors++; $display("FAIL ram_retained got %h want a5", data_read); end
        for (int k = 0; k < 70; k++) idle();
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL post_reset_irq got %b want 0", timer_irq); end
        bus(16'hD003, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'h00) begin errors++; $display("FAIL post_reset_status got %h want 00", data_read); end
        bus(16'hD002, 1'b1, 8'h00);
        checks++;
        if (data_read !== 8'h00) begin errors++; $display("FAIL post_reset_ctrl got %h want 00", data_read); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_vectors();
        test_unmapped();
        test_port();
`ifdef BUS_RESPONDER_TIMER_EN
        test_timer_auto(3);
        test_timer_auto(0);
        test_timer_auto($urandom_range(1, 6));
        test_timer_oneshot(2);
        test_timer_oneshot($urandom_range(0, 5));
        test_timer_snapshot();
`else
        test_timer_absent();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The block SHALL take parameter RAM_ADDR_BITS, default 11, giving the RAM size (2^RAM_ADDR_BITS bytes, based at 0x0000).
REQ-002 The block SHALL take parameter RESET_VECTOR, default 16'h0200, giving the value returned at 0xFFFC/0xFFFD.
REQ-003 The block SHALL take parameter IRQ_VECTOR, default 16'h0300, giving the value returned at 0xFFFE/0xFFFF.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 address  input  16  bus address driven by the CPU.
REQ-007 read_write  input  1  1 = read, 0 = write.
REQ-008 data_write  input  8  write data, sampled when read_write = 0.
REQ-009 data_read  output  8  registered read data returned to the CPU.
REQ-010 port_out  output  8  general-purpose output port register.
REQ-011 timer_irq  output  1  timer interrupt request, active-high, level.

Function
REQ-012 Memory map SHALL be as follows:
- RAM at 0x0000..(2^RAM_ADDR_BITS - 1).
- TIMER_RELOAD_LO 0xD000, TIMER_RELOAD_HI 0xD001, TIMER_CTRL 0xD002, TIMER_STATUS 0xD003.
- PORT 0xD004.
- COUNT_LO 0xD005, COUNT_HI 0xD006.
- Vectors 0xFFFC..0xFFFF.
REQ-013 Read latency SHALL be 1 cycle: data_read after edge N SHALL reflect the address presented with read_write = 1 in cycle N.
REQ-014 data_read SHALL hold its value through write cycles.
REQ-015 Reads of unmapped addresses SHALL return 0x00, and writes to unmapped addresses or vectors SHALL be ignored.
REQ-016 A RAM read in the cycle after a write to the same address SHALL return the newly written byte.
REQ-017 TIMER_CTRL bits:
- bit0 = enable.
- bit1 = auto-reload.
- bit2 = irq enable.
- bits 7:3 read as 0.
REQ-018 The timer SHALL have two states, IDLE and RUN.
- Writing CTRL with bit0 = 1 SHALL load the 16-bit counter from {RELOAD_HI, RELOAD_LO} and enter RUN.
- Writing CTRL with bit0 = 0 SHALL enter IDLE and freeze the counter.
REQ-019 In RUN, the counter SHALL decrement by 1 each cycle.
REQ-020 In RUN with counter = 0x0000, the next edge SHALL set STATUS bit0 (expired). It SHALL then either reload from the reload registers and stay in RUN (auto-reload = 1), or clear CTRL bit0 and go to IDLE (auto-reload = 0).
REQ-021 A reload value of 0x0000 with auto-reload SHALL expire every cycle, and the counter SHALL never wrap to 0xFFFF.
REQ-022 STATUS bit0 SHALL be write-1-to-clear. If expiry and the clear occur in the same cycle, the set SHALL win.
REQ-023 timer_irq SHALL equal STATUS bit0 AND CTRL bit2, registered-state derived with no extra latency.
REQ-024 Reading COUNT_LO SHALL return the low counter byte and capture the high byte into a snapshot register. COUNT_HI SHALL return that snapshot, not the live byte.
REQ-025 PORT SHALL be read/write, and port_out SHALL reflect it directly.
REQ-026 Writes to reload registers during RUN SHALL take effect only at the next reload or CTRL enable.

Reset
REQ-027 While rst = 1, the following SHALL be 0x00 (or 0) regardless of clk: data_read, port_out, timer_irq, CTRL, STATUS, the reload registers, the counter and the snapshot; the timer SHALL be in IDLE.
REQ-028 RAM contents SHALL NOT be reset.
REQ-029 Reset asserted mid-count SHALL abort the count, with no expiry flagged.

Configuration
REQ-030 Macro BUS_RESPONDER_TIMER_EN SHALL control whether the timer is built.
- Defined: the timer (REQ-017..REQ-024, REQ-026) SHALL be built.
- Undefined: no timer logic SHALL exist. Reads of 0xD000..0xD003 and 0xD005..0xD006 SHALL return 0x00, writes to them SHALL be ignored, and timer_irq SHALL be constant 0.
- The RAM, PORT and vectors SHALL be unaffected.

Verification
REQ-031 Write 0xA5 to 0x0123, then read 0x0123 the next cycle: data_read = 0xA5 one cycle later.
REQ-032 Read 0xFFFC then 0xFFFD with defaults: data_read = 0x00, then 0x02. Write 0x55 to 0xFFFC, then read 0xFFFC: still 0x00.
REQ-033 Reload = 0x0003, CTRL = 0x07: STATUS bit0 and timer_irq rise 4 cycles after the CTRL write edge, then rise again every 4 cycles. Writing 0x01 to STATUS clears them.
REQ-034 Reload = 0x0002, CTRL = 0x05 (one-shot): expiry after 3 cycles. CTRL then reads 0x04 and the counter holds 0x0000.
REQ-035 Counter at 0x0100: read COUNT_LO then COUNT_HI two cycles later: returns 0x00 and 0x01 (snapshot), not the live 0x00.
REQ-036 Assert rst mid-count with PORT = 0x3C: port_out, data_read and timer_irq go to 0 immediately, without waiting for a clk edge; RAM byte 0x0123 is retained.
